// File: rtl/gray_mean_threshold.sv
// Global binarization threshold: floor of the mean gray level read from the BMP RAM.
// Accumulates one byte per pixel, then runs a restoring divide by the constant pixel count.
module gray_mean_threshold #(
  parameter int BYTE_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 20,
  parameter int HEADER_SIZE     = 54,
  parameter int BYTES_PER_PIXEL = 3,
  parameter int PIXEL_COUNT     = 262144
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BYTE_WIDTH-1:0] RAM_out,
  output logic                  RAM_ren,
  output logic                  RAM_wen,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic [BYTE_WIDTH-1:0] threshold,
  output logic                  done
);

  // state | meaning
  // IDLE  | waiting for start from the gray stage
  // READ  | one RAM read per cycle, idx = 0..N-1
  // DRAIN | absorb the last read byte, load the divider
  // DIV   | restoring divide, one quotient bit per cycle
  // DONE  | threshold valid, held until rst

  localparam int SUM_WIDTH = BYTE_WIDTH + $clog2(PIXEL_COUNT);
  localparam int REM_WIDTH = $clog2(PIXEL_COUNT) + 2;
  localparam int IDX_WIDTH = $clog2(PIXEL_COUNT) + 1;
  localparam int CNT_WIDTH = $clog2(SUM_WIDTH + 1);

  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(PIXEL_COUNT - 1);
  localparam logic [REM_WIDTH-1:0] N_REM    = REM_WIDTH'(PIXEL_COUNT);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [IDX_WIDTH-1:0] idx;
  logic                 rd_vld;
  logic [SUM_WIDTH-1:0] sum, sum_nxt;
  logic [SUM_WIDTH-1:0] dividend, quotient;
  logic [REM_WIDTH-1:0] rem, rem_shift;
  logic                 rem_ge;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 unused_bits;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (idx == IDX_LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = DIV;
      DIV:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // The remainder entering a step is < N, so the shifted value is < 2N and fits REM_WIDTH.
  always_comb begin
    sum_nxt   = rd_vld ? sum + SUM_WIDTH'(RAM_out) : sum;
    rem_shift = {rem[REM_WIDTH-2:0], dividend[SUM_WIDTH-1]};
    rem_ge    = (rem_shift >= N_REM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      rd_vld   <= 1'b0;
      sum      <= '0;
      dividend <= '0;
      quotient <= '0;
      rem      <= '0;
      cnt      <= '0;
    end else begin
      rd_vld <= (state == READ);
      sum    <= sum_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            sum <= '0;
            idx <= '0;
          end
        end
        READ: idx <= idx + 1'b1;
        DRAIN: begin
          dividend <= sum_nxt;
          rem      <= '0;
          quotient <= '0;
          cnt      <= CNT_WIDTH'(SUM_WIDTH - 1);
        end
        DIV: begin
          dividend <= dividend << 1;
          rem      <= rem_ge ? rem_shift - N_REM : rem_shift;
          quotient <= {quotient[SUM_WIDTH-2:0], rem_ge};
          cnt      <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    RAM_ren   = (state == READ);
    RAM_wen   = 1'b0;
    RAM_addr  = (state == READ)
              ? ADDR_WIDTH'(HEADER_SIZE) + ADDR_WIDTH'(BYTES_PER_PIXEL) * ADDR_WIDTH'(idx)
              : '0;
    done      = (state == DONE);
    threshold = (state == DONE) ? quotient[BYTE_WIDTH-1:0] : '0;
  end

  // Upper quotient bits and the remainder MSB are zero by construction at DONE.
  assign unused_bits = ^{quotient, rem[REM_WIDTH-1]};

endmodule

// File: tb/tb_gray_mean_threshold.sv
// Directed bench for gray_mean_threshold with N=4 and N=3 instances sharing start/rst.
module tb_gray_mean_threshold;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [7:0]  out4, out3;
  logic        ren4, wen4, ren3, wen3;
  logic [19:0] addr4, addr3;
  logic [7:0]  thr4, thr3;
  logic        done4, done3;
  logic [7:0]  mem4 [256];
  logic [7:0]  mem3 [256];

  int checks = 0;
  int errors = 0;

  logic        sel3 = 1'b0;
  logic        ren_m, wen_m, done_m;
  logic [19:0] addr_m;
  logic [7:0]  thr_m;
  assign ren_m  = sel3 ? ren3  : ren4;
  assign wen_m  = sel3 ? wen3  : wen4;
  assign done_m = sel3 ? done3 : done4;
  assign addr_m = sel3 ? addr3 : addr4;
  assign thr_m  = sel3 ? thr3  : thr4;

  gray_mean_threshold #(.PIXEL_COUNT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .RAM_out(out4), .RAM_ren(ren4),
    .RAM_wen(wen4), .RAM_addr(addr4), .threshold(thr4), .done(done4));

  gray_mean_threshold #(.PIXEL_COUNT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .RAM_out(out3), .RAM_ren(ren3),
    .RAM_wen(wen3), .RAM_addr(addr3), .threshold(thr3), .done(done3));

  always @(posedge clk) begin
    if (ren4) out4 <= mem4[addr4[7:0]];
    if (ren3) out3 <= mem3[addr3[7:0]];
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load4(input int p0, input int p1, input int p2, input int p3);
    mem4[54] = 8'(p0);
    mem4[57] = 8'(p1);
    mem4[60] = 8'(p2);
    mem4[63] = 8'(p3);
  endtask

  // Called at a negedge. Raises start; the following posedge is E0.
  task automatic run(input int n, input int exp_thr, input int exp_lat, input bit hold,
                     input string tag);
    int lat = 0;
    int rens = 0;
    bit addr_bad = 0;
    bit wen_bad = 0;
    logic [19:0] bad_addr = '0;
    start = 1'b1;
    @(posedge clk);
    while (1) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (wen_m !== 1'b0) wen_bad = 1;
      if (ren_m === 1'b1) begin
        if (addr_m !== 20'(54 + 3 * rens)) begin
          addr_bad = 1;
          bad_addr = addr_m;
        end
        rens++;
      end
      if (done_m === 1'b1 || lat >= 200) break;
      @(posedge clk);
      lat++;
    end
    checks++;
    if (done_m !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d edges, required 1", tag, done_m, lat);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, required %0d", tag, lat, exp_lat);
    end
    checks++;
    if (thr_m !== 8'(exp_thr)) begin
      errors++;
      $display("FAIL %s threshold: got %0d, required %0d", tag, thr_m, exp_thr);
    end
    checks++;
    if (rens != n) begin
      errors++;
      $display("FAIL %s ren_count: got %0d, required %0d", tag, rens, n);
    end
    checks++;
    if (addr_bad) begin
      errors++;
      $display("FAIL %s addr_seq: got %0d, required 54+3*idx", tag, bad_addr);
    end
    checks++;
    if (wen_bad) begin
      errors++;
      $display("FAIL %s wen: got 1, required 0", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ren4, wen4, done4} !== 3'b000 || addr4 !== 20'd0 || thr4 !== 8'd0) begin
      errors++;
      $display("FAIL reset_n4: ren=%b wen=%b done=%b addr=%0d thr=%0d, required all 0",
               ren4, wen4, done4, addr4, thr4);
    end
    checks++;
    if ({ren3, wen3, done3} !== 3'b000 || addr3 !== 20'd0 || thr3 !== 8'd0) begin
      errors++;
      $display("FAIL reset_n3: ren=%b wen=%b done=%b addr=%0d thr=%0d, required all 0",
               ren3, wen3, done3, addr3, thr3);
    end
    rst = 1'b0;
  endtask

  task automatic test_mean();
    sel3 = 1'b0;
    load4(10, 20, 30, 40);
    do_reset();
    run(4, 25, 15, 1'b1, "mean_10_40");
  endtask

  task automatic test_extremes();
    sel3 = 1'b0;
    load4(255, 255, 255, 255);
    do_reset();
    run(4, 255, 15, 1'b1, "all_255");
    load4(0, 0, 0, 0);
    do_reset();
    run(4, 0, 15, 1'b1, "all_0");
  endtask

  task automatic test_truncate();
    sel3 = 1'b1;
    mem3[54] = 8'd1;
    mem3[57] = 8'd1;
    mem3[60] = 8'd2;
    do_reset();
    run(3, 1, 14, 1'b1, "trunc_n3");
    sel3 = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    sel3 = 1'b0;
    load4(10, 20, 30, 40);
    do_reset();
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (addr4 !== 20'd60 || ren4 !== 1'b1) begin
      errors++;
      $display("FAIL midread_pos: addr=%0d ren=%b, required 60 and 1", addr4, ren4);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ren4, wen4, done4} !== 3'b000 || addr4 !== 20'd0 || thr4 !== 8'd0) begin
      errors++;
      $display("FAIL midread_rst: ren=%b wen=%b done=%b addr=%0d thr=%0d, required all 0",
               ren4, wen4, done4, addr4, thr4);
    end
    rst = 1'b0;
    run(4, 25, 15, 1'b1, "rerun");
  endtask

  task automatic test_hold_after_done();
    int ren_seen = 0;
    bit done_drop = 0;
    bit thr_chg = 0;
    bit wen_bad = 0;
    sel3 = 1'b0;
    load4(10, 20, 30, 40);
    do_reset();
    run(4, 25, 15, 1'b0, "pulse");
    start = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (ren4 !== 1'b0) ren_seen++;
      if (done4 !== 1'b1) done_drop = 1;
      if (thr4 !== 8'd25) thr_chg = 1;
      if (wen4 !== 1'b0) wen_bad = 1;
    end
    start = 1'b0;
    checks++;
    if (ren_seen != 0) begin
      errors++;
      $display("FAIL hold_ren: got %0d extra read cycles, required 0", ren_seen);
    end
    checks++;
    if (done_drop) begin
      errors++;
      $display("FAIL hold_done: done fell, required stable 1");
    end
    checks++;
    if (thr_chg) begin
      errors++;
      $display("FAIL hold_thr: threshold changed, required stable 25");
    end
    checks++;
    if (wen_bad) begin
      errors++;
      $display("FAIL hold_wen: got 1, required 0");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem4[i] = 8'hEE;
      mem3[i] = 8'hEE;
    end
    out4 = '0;
    out3 = '0;
    test_reset();
    test_mean();
    test_extremes();
    test_truncate();
    test_reset_mid_read();
    test_hold_after_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
